uart_fifo_csr: RTL

//  Parametrised Wishbone CSR + buffering layer for the user-area UART. Sits between the WB slave bus
//  and the uart_receive / uart_transmission engines. Provides TX/RX FIFOs of configurable depth and width,
//  a runtime baud divisor, sticky error flags, and a threshold-based level IRQ on user_irq[0].

---
 rtl/uart_fifo_csr.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_csr.sv
// ---------------------------------------------------------------------------
// uart_fifo_csr
// Wishbone CSR and buffering layer for the user-area UART. It sits between the
// WB slave bus and the uart_receive / uart_transmission engines, and provides:
//   - TX and RX FIFOs (DEPTH entries of DATA_W bits each)
//   - a runtime baud divisor
//   - sticky error flags
//   - a level interrupt driven by thresholds and enables
//
// Ports
//   wb_clk_i, wb_rst_i      clock; synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    WB cycle, strobe and write enable
//   wbs_sel_i[3:0]          byte selects (honoured by CLKDIV only)
//   wbs_adr_i[31:0]         byte address; window decoded on [31:8]
//   wbs_dat_i[31:0]         write data
//   wbs_ack_o               single-cycle acknowledge
//   wbs_dat_o[31:0]         read data, valid with ack
//   tx_valid, tx_data       TX FIFO head towards the transmitter
//   tx_ready                transmitter takes the head (pop on valid&ready)
//   rx_valid, rx_data       one-cycle pulse carrying a received character
//   rx_frame_err            qualifies rx_valid: stop-bit error
//   tx_busy                 transmitter is shifting
//   clk_div[31:0]           baud divisor to both engines
//   irq                     level interrupt
// ---------------------------------------------------------------------------
module uart_fifo_csr #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DATA_W    = 8,
    parameter int          DEPTH     = 16,
    parameter int          CLK_FREQ  = 40000000,
    parameter int          BAUD_RATE = 9600
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_frame_err,
    input  logic              tx_busy,
    output logic [31:0]       clk_div,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0]   DIV_RAW  = 32'(CLK_FREQ / BAUD_RATE);
    localparam logic [31:0]   DIV_RST  = (DIV_RAW == 32'd0) ? 32'd1 : DIV_RAW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] PTR_ONE  = CW'(1);

    localparam logic [7:0] OFF_RXDATA = 8'h00;
    localparam logic [7:0] OFF_TXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_CLKDIV = 8'h10;

    // Storage and state
    logic [DATA_W-1:0] rx_mem_r [DEPTH];
    logic [DATA_W-1:0] tx_mem_r [DEPTH];
    logic [CW-1:0]     rx_wptr_r, rx_rptr_r, tx_wptr_r, tx_rptr_r;
    logic              ack_r;
    logic [31:0]       dat_r;
    logic              rx_ovr_r, frame_err_r, tx_ovf_r;
    logic [2:0]        irq_en_r;      // [0] rx, [1] tx, [2] err
    logic [7:0]        rx_thresh_r;
    logic [31:0]       clk_div_r;
    logic              irq_r;

    // Bus decode
    logic       req_s, acc_s, wr_s, rd_s;
    logic [7:0] off_s;

    // FIFO status and handshakes
    logic [CW-1:0] rx_count_s, tx_count_s;
    logic          rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic          rx_pop_s, rx_push_s, rx_drop_s;
    logic          tx_pop_s, tx_push_req_s, tx_push_s, tx_drop_s;
    logic          w1c_s;

    // Register side effects and read data
    logic [31:0] clk_div_next_s;
    logic [31:0] rdata_s;
    logic [7:0]  thresh_eff_s;
    logic        irq_s;

    // An access is taken only when no ack is pending, so a held strobe is
    // acked every other cycle and each side effect fires exactly once.
    assign req_s = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc_s = req_s & ~ack_r;
    assign wr_s  = acc_s & wbs_we_i;
    assign rd_s  = acc_s & ~wbs_we_i;
    assign off_s = wbs_adr_i[7:0];

    // Pointers carry one extra bit, so full and empty are distinguishable
    // by the count alone.
    assign rx_count_s = rx_wptr_r - rx_rptr_r;
    assign tx_count_s = tx_wptr_r - tx_rptr_r;
    assign rx_empty_s = (rx_count_s == '0);
    assign tx_empty_s = (tx_count_s == '0);
    assign rx_full_s  = (rx_count_s == FULL_CNT);
    assign tx_full_s  = (tx_count_s == FULL_CNT);

    // A pop on a full FIFO frees the slot that a same-cycle push then uses.
    assign rx_pop_s      = rd_s & (off_s == OFF_RXDATA) & ~rx_empty_s;
    assign rx_push_s     = rx_valid & (~rx_full_s | rx_pop_s);
    assign rx_drop_s     = rx_valid & rx_full_s & ~rx_pop_s;

    assign tx_pop_s      = ~tx_empty_s & tx_ready;
    assign tx_push_req_s = wr_s & (off_s == OFF_TXDATA);
    assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s);
    assign tx_drop_s     = tx_push_req_s & tx_full_s & ~tx_pop_s;

    assign w1c_s = wr_s & (off_s == OFF_STATUS);

    assign tx_valid  = ~tx_empty_s;
    assign tx_data   = tx_mem_r[tx_rptr_r[AW-1:0]];
    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign clk_div   = clk_div_r;
    assign irq       = irq_r;

    // CLKDIV merge: byte-lane update; a zero divisor is stored as 1.
    always_comb begin
        clk_div_next_s = clk_div_r;
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                clk_div_next_s[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end else begin
                clk_div_next_s[8*b +: 8] = clk_div_r[8*b +: 8];
            end
        end
        if (clk_div_next_s == 32'd0) begin
            clk_div_next_s = 32'd1;
        end else begin
            clk_div_next_s = clk_div_next_s;
        end
    end

    // Read-data multiplexer.
    always_comb begin
        rdata_s = 32'd0;
        case (off_s)
            OFF_RXDATA: begin
                if (rx_empty_s) begin
                    rdata_s = 32'h8000_0000;
                end else begin
                    rdata_s = 32'(rx_mem_r[rx_rptr_r[AW-1:0]]);
                end
            end
            OFF_STATUS: rdata_s = {8'd0, 8'(tx_count_s), 8'(rx_count_s),
                                   tx_busy, tx_ovf_r, frame_err_r, rx_ovr_r,
                                   tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
            OFF_CTRL:   rdata_s = {16'd0, rx_thresh_r, 5'd0, irq_en_r};
            OFF_CLKDIV: rdata_s = clk_div_r;
            default:    rdata_s = 32'd0;
        endcase
    end

    // Interrupt condition; a zero threshold behaves like a threshold of 1.
    always_comb begin
        if (rx_thresh_r == 8'd0) begin
            thresh_eff_s = 8'd1;
        end else begin
            thresh_eff_s = rx_thresh_r;
        end
        irq_s = (irq_en_r[0] & (16'(rx_count_s) >= {8'd0, thresh_eff_s}))
              | (irq_en_r[1] & tx_empty_s & ~tx_busy)
              | (irq_en_r[2] & (rx_ovr_r | frame_err_r | tx_ovf_r));
    end

    // FIFO storage writes; the contents need no reset because the pointers define validity.
    always_ff @(posedge wb_clk_i) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wptr_r[AW-1:0]] <= rx_data;
        end
        if (tx_push_s) begin
            tx_mem_r[tx_wptr_r[AW-1:0]] <= wbs_dat_i[DATA_W-1:0];
        end
    end

    // Control state: bus handshake, pointers, sticky flags, CSRs and irq.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r       <= 1'b0;
            dat_r       <= 32'd0;
            rx_wptr_r   <= '0;
            rx_rptr_r   <= '0;
            tx_wptr_r   <= '0;
            tx_rptr_r   <= '0;
            rx_ovr_r    <= 1'b0;
            frame_err_r <= 1'b0;
            tx_ovf_r    <= 1'b0;
            irq_en_r    <= 3'd0;
            rx_thresh_r <= 8'd0;
            clk_div_r   <= DIV_RST;
            irq_r       <= 1'b0;
        end else begin
            ack_r <= acc_s;
            dat_r <= rd_s ? rdata_s : 32'd0;

            if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;

            // A new event in the same cycle as its W1C keeps the flag set.
            rx_ovr_r    <= rx_drop_s | (rx_ovr_r & ~(w1c_s & wbs_dat_i[4]));
            frame_err_r <= (rx_valid & rx_frame_err)
                         | (frame_err_r & ~(w1c_s & wbs_dat_i[5]));
            tx_ovf_r    <= tx_drop_s | (tx_ovf_r & ~(w1c_s & wbs_dat_i[6]));

            if (wr_s && (off_s == OFF_CTRL)) begin
                irq_en_r    <= wbs_dat_i[2:0];
                rx_thresh_r <= wbs_dat_i[15:8];
            end
            if (wr_s && (off_s == OFF_CLKDIV)) begin
                clk_div_r <= clk_div_next_s;
            end

            irq_r <= irq_s;
        end
    end

endmodule
